// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_size_t  - access size encoding (byte/half/word/doubleword)
//   lsu_state_t - load_store_unit FSM states
//   misaligned  - true when the byte offset is not a multiple of the size
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } lsu_state_t;

  function automatic logic misaligned(input lsu_size_t size, input logic [2:0] off);
    case (size)
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      SZ_D:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane steering for sub-doubleword accesses.
//   held   in  64 : doubleword read from memory
//   wdata  in  64 : store data, LSBs significant
//   off    in   3 : byte offset within the doubleword
//   size   in     : access size
//   zext   in   1 : zero-extend the load instead of sign-extending
//   rdata  out 64 : extracted and extended load value
//   merged out 64 : held doubleword with the store lanes replaced
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [63:0] held,
  input  logic [63:0] wdata,
  input  logic [2:0]  off,
  input  lsu_size_t   size,
  input  logic        zext,
  output logic [63:0] rdata,
  output logic [63:0] merged
);

  logic [63:0] shifted;

  always_comb begin
    shifted = held >> {off, 3'b000};
    rdata   = '0;
    merged  = held;
    case (size)
      SZ_B: begin
        rdata = zext ? {56'b0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        rdata = zext ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
        merged[{off, 3'b000} +: 16] = wdata[15:0];
      end
      SZ_W: begin
        rdata = zext ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
        merged[{off, 3'b000} +: 32] = wdata[31:0];
      end
      SZ_D: begin
        // A reachable dword access is aligned, so off is 0 and shifted == held.
        rdata  = shifted;
        merged = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time byte/half/word/dword load/store engine in
// front of a 64-bit Data_Memory. Narrow stores are read-modify-write.
//   req_*      : request channel (valid/ready), latched on acceptance
//   resp_*     : response channel (valid/ready), rdata 0 for stores/errors
//   MemRead/MemWrite/Mem_Addr/Write_Data/Read_Data : memory port
//                (Read_Data combinational, write on the edge ending WR)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [63:0]       Write_Data,
  input  logic [63:0]       Read_Data
);

  lsu_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  lsu_size_t         size_q;
  logic              write_q;
  logic              zext_q;
  logic [63:0]       wdata_q;
  logic [63:0]       held_q;
  logic              err_q;

  logic [63:0]       load_data;
  logic [63:0]       merged;
  lsu_size_t         req_sz;
  logic              req_mis;

  assign req_sz  = lsu_size_t'(req_size);
  assign req_mis = misaligned(req_sz, req_addr[2:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= SZ_B;
      write_q <= 1'b0;
      zext_q  <= 1'b0;
      wdata_q <= '0;
      held_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            size_q  <= req_sz;
            write_q <= req_write;
            zext_q  <= req_unsigned;
            wdata_q <= req_wdata;
            err_q   <= req_mis;
            if (req_mis)                     state <= ST_RESP;
            else if (!req_write)             state <= ST_RD;
            else if (req_sz == SZ_D)         state <= ST_WR;
            else                             state <= ST_RD;
          end
        end
        ST_RD: begin
          held_q <= Read_Data;
          state  <= write_q ? ST_WR : ST_RESP;
        end
        ST_WR:   state <= ST_RESP;
        ST_RESP: if (resp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  lsu_lane_align u_align (
    .held   (held_q),
    .wdata  (wdata_q),
    .off    (addr_q[2:0]),
    .size   (size_q),
    .zext   (zext_q),
    .rdata  (load_data),
    .merged (merged)
  );

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign MemRead    = (state == ST_RD);
  assign MemWrite   = (state == ST_WR);
  assign resp_err   = (state == ST_RESP) && err_q;
  assign resp_rdata = ((state == ST_RESP) && !write_q && !err_q) ? load_data : '0;
  assign Mem_Addr   = (MemRead || MemWrite) ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign Write_Data = MemWrite ? merged : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed self-checking bench for
// load_store_unit against a byte-addressed reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        MemRead, MemWrite;
  logic [63:0] Mem_Addr, Write_Data, Read_Data;

  int tests = 0;
  int failed = 0;

  // Environment memory (stands in for Data_Memory): 32 doublewords, aliased.
  logic [63:0] dmem [0:31];
  // Reference model: plain byte array with the same aliasing (addr mod 256).
  logic [7:0]  ref_mem [0:255];

  always #5 clk = ~clk;

  assign Read_Data = dmem[Mem_Addr[7:3]];
  always @(posedge clk) if (MemWrite) dmem[Mem_Addr[7:3]] <= Write_Data;

  load_store_unit #(.ADDR_W(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .Mem_Addr(Mem_Addr),
    .Write_Data(Write_Data), .Read_Data(Read_Data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_dword(input logic [63:0] a);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = ref_mem[{a[7:3], 3'b000} + 8'(i)];
    return v;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input int n, input bit uns);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = ref_mem[a[7:0] + 8'(i)];
    if (!uns && n < 8 && v[n*8-1]) v = v | (~64'd0 << (n*8));
    return v;
  endfunction

  // One request through the DUT; checks memory activity, latency, response.
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [63:0] a, input logic [63:0] wd,
                        input int hold, output logic [63:0] rd);
    int n = 1 << sz;
    bit mis = (a[2:0] % n) != 0;
    int exp_lat = mis ? 1 : (!wr ? 2 : (sz == 2'd3 ? 2 : 3));
    int exp_rds = (mis || (wr && sz == 2'd3)) ? 0 : 1;
    int exp_wrs = (!mis && wr) ? 1 : 0;
    logic [63:0] exp_rd = '0;
    logic [63:0] exp_wd = '0;
    logic [63:0] snap;
    int cyc = 0, rds = 0, wrs = 0;
    bit got = 0;
    if (!mis && !wr) exp_rd = ref_load(a, n, uns);
    if (!mis && wr) begin
      for (int i = 0; i < n; i++) ref_mem[a[7:0] + 8'(i)] = wd[i*8 +: 8];
      exp_wd = ref_dword(a);
    end
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (MemRead) begin
        rds++;
        check("rd_addr", Mem_Addr, {a[63:3], 3'b000});
      end
      if (MemWrite) begin
        wrs++;
        check("wr_addr", Mem_Addr, {a[63:3], 3'b000});
        check("write_data", Write_Data, exp_wd);
      end
      if (resp_valid) got = 1;
    end
    check("latency", 64'(cyc), 64'(exp_lat));
    check("mem_reads", 64'(rds), 64'(exp_rds));
    check("mem_writes", 64'(wrs), 64'(exp_wrs));
    check("resp_err", 64'(resp_err), 64'(mis));
    check("resp_rdata", resp_rdata, exp_rd);
    rd = resp_rdata;
    snap = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(resp_valid), 64'd1);
      check("bp_rdata", resp_rdata, snap);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_mem_idle", 64'({MemRead, MemWrite}), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("back_idle", 64'({req_ready, resp_valid}), 64'b10);
  endtask

  initial begin
    logic [63:0] r;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dmem[i] = {$urandom(), $urandom()};
      for (int b = 0; b < 8; b++) ref_mem[i*8 + b] = dmem[i][b*8 +: 8];
    end
    #2;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_flags", 64'({resp_valid, resp_err, MemRead, MemWrite}), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_mem_addr", Mem_Addr, 64'd0);
    check("rst_write_data", Write_Data, 64'd0);
    @(negedge clk); reset = 1'b0;

    // Dword store / load round trip.
    do_req(1, 2'd3, 0, 64'd0, 64'd100, 0, r);
    do_req(0, 2'd3, 0, 64'd0, 64'd0, 0, r);
    check("ld_100", r, 64'd100);

    // Sign/zero extension.
    do_req(1, 2'd3, 0, 64'd8, 64'h0000_0000_8000_00FF, 0, r);
    do_req(0, 2'd0, 0, 64'd8, 64'd0, 0, r);
    check("lb_8", r, 64'hFFFF_FFFF_FFFF_FFFF);
    do_req(0, 2'd0, 1, 64'd8, 64'd0, 0, r);
    check("lbu_8", r, 64'h0000_0000_0000_00FF);
    do_req(0, 2'd2, 0, 64'd12, 64'd0, 0, r);
    check("lw_12", r, 64'h0);
    do_req(0, 2'd2, 0, 64'd8, 64'd0, 0, r);
    check("lw_8", r, 64'hFFFF_FFFF_8000_00FF);

    // Narrow store RMW.
    do_req(1, 2'd3, 0, 64'd16, 64'h1111_2222_3333_4444, 0, r);
    do_req(1, 2'd1, 0, 64'd18, 64'hABCD, 0, r);
    do_req(0, 2'd3, 0, 64'd16, 64'd0, 0, r);
    check("sh_merge", r, 64'h1111_2222_ABCD_4444);

    // Misaligned word.
    do_req(0, 2'd2, 0, 64'd10, 64'd0, 0, r);

    // Backpressure on a dword load.
    do_req(1, 2'd3, 0, 64'd8, 64'd150, 0, r);
    do_req(0, 2'd3, 0, 64'd8, 64'd0, 4, r);
    check("ld_150", r, 64'd150);

    // Reset in WR: write lost, outputs back to reset values.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'd24; req_wdata = 64'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_rst_memwrite", 64'(MemWrite), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_wr_memwrite", 64'(MemWrite), 64'd0);
    check("rst_wr_req_ready", 64'(req_ready), 64'd1);
    check("rst_wr_flags", 64'({resp_valid, resp_err, MemRead}), 64'd0);
    check("rst_wr_buses", Mem_Addr | Write_Data | resp_rdata, 64'd0);
    @(negedge clk); reset = 1'b0;
    do_req(0, 2'd3, 0, 64'd24, 64'd0, 0, r);

    // Random traffic, including high address bits and misalignment.
    for (int k = 0; k < 300; k++) begin
      logic [63:0] a;
      a = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 0) a[63:8] = '0;
      if ($urandom_range(0, 9) == 0) a[63:8] = '1;
      do_req(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)), a, {$urandom(), $urandom()},
             int'($urandom_range(0, 2)), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sub-doubleword load/store engine between the EX/MEM stage and the 64-bit `Data_Memory`. It accepts one byte, half, word or doubleword request at a time and drives the memory's `MemRead`/`MemWrite`/`Mem_Addr`/`Write_Data` port. Narrow stores become a read-modify-write of the enclosing doubleword. Load data is returned sign- or zero-extended through a valid/ready response.

## Interface
- `ADDR_W`, 64: request and memory address width.
- `clk`  in  1: rising-edge clock; `Data_Memory` shares it.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: high only in IDLE.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 0 byte, 1 half, 2 word, 3 doubleword.
- `req_unsigned`  in  1: zero-extend the load (lbu/lhu/lwu); ignored for stores.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  64: store data, LSBs significant.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_rdata`  out  64: extended load data; 0 for stores and errors.
- `resp_err`  out  1: misaligned request.
- `MemRead`  out  1: memory read enable.
- `MemWrite`  out  1: memory write enable.
- `Mem_Addr`  out  ADDR_W: doubleword-aligned memory address, `{addr[ADDR_W-1:3],3'b000}`.
- `Write_Data`  out  64: full doubleword to write.
- `Read_Data`  in  64: combinational read data from memory.

## Operation
- States: IDLE, RD, WR, RESP. The request is latched (addr, size, write, unsigned, wdata) on acceptance, i.e. when `req_valid & req_ready`.
- Misaligned if: half with `addr[0]≠0`; word with `addr[1:0]≠0`; dword with `addr[2:0]≠0`.
- Accept transitions:
  - misaligned: IDLE→RESP, `resp_err`=1, no memory access.
  - load: IDLE→RD→RESP.
  - dword store: IDLE→WR→RESP.
  - narrow store: IDLE→RD→WR→RESP.
- RD: `MemRead`=1. `Read_Data` is captured at the end of the cycle into a 64-bit holding register.
- WR: `MemWrite`=1.
  - `Write_Data` = `req_wdata` for a dword store.
  - Otherwise it is the held doubleword with lanes `[off*8 +: n*8]` replaced by `wdata[n*8-1:0]`, where `off = addr[2:0]` and n = 1/2/4 bytes.
- RESP: `resp_valid`=1 and is held until `resp_ready`, then →IDLE.
- Load result = `held >> (off*8)`, truncated to the access size, then sign-extended from its MSB or zero-extended if `req_unsigned`. A dword load returns `held` unchanged.
- `MemRead`, `MemWrite`, `req_ready` and `resp_valid` decode from state only.
- `Mem_Addr` is 0 outside RD/WR.

## Timing
- Reset (async): state IDLE.
  - Outputs: `req_ready`=1; `resp_valid`, `resp_err`, `MemRead`, `MemWrite`=0.
  - Buses: `resp_rdata`, `Mem_Addr`, `Write_Data`=0; holding registers cleared.
- Latency from the accept edge to the first `resp_valid` cycle (one state per cycle): load 2 cycles, dword store 2, narrow store 3, misaligned 1.
- `Data_Memory` writes on the rising edge at the end of the WR cycle. Its read is combinational during RD.
- Back-to-back: a new request is accepted on the cycle after the RESP handshake, so peak throughput is one request per 3 cycles.
- `resp_ready` held low: the response and all outputs are frozen; no memory activity.
- `req_valid` outside IDLE is ignored (`req_ready`=0).
- Reset asserted in WR drops `MemWrite` immediately and the write is lost. Reset in RD/RESP discards the request.
- Address arithmetic wraps mod 2^ADDR_W. Lane shifts use only `addr[2:0]`.

## Structure
- `lsu_pkg`: size encodings (`SZ_B/H/W/D`), state enum, and the `misaligned(size, off)` function.
- Sub-module `lsu_lane_align` (combinational):
  - load extract/extend: `held, off, size, unsigned → rdata`;
  - store merge: `held, wdata, off, size → merged`.
- FSM and registers live in `load_store_unit`.

## Test plan
- Reset mid-WR of store dword 0x1234 → `MemWrite` falls within the same cycle; memory location unchanged; all outputs reset values; `req_ready`=1.
- Store dword: addr 0, data 100 → WR cycle with `Mem_Addr`=0, `Write_Data`=100. Then load dword addr 0 → `resp_rdata`=100 two cycles after accept.
- Sign/zero extension: memory[8]=0x0000_0000_8000_00FF.
  - lb addr 8 → 0xFFFF_FFFF_FFFF_FFFF.
  - lbu addr 8 → 0xFF.
  - lw addr 12 → 0x0000_0000_0000_0000.
  - lw addr 8 → 0xFFFF_FFFF_8000_00FF.
- Narrow store RMW: memory[16]=0x1111_2222_3333_4444; sh addr 18 data 0xABCD → RD then WR with `Write_Data`=0x1111_2222_ABCD_4444; `resp_valid` 3 cycles after accept.
- Misaligned: lw addr 10 → `resp_err`=1 next cycle; `MemRead`/`MemWrite` never asserted; `resp_rdata`=0.
- Backpressure: `resp_ready`=0 for 4 cycles after a load of 150 from addr 10 aligned to 8 (ld addr 8) → `resp_valid`, `resp_rdata` stable; `req_ready`=0 throughout; returns to IDLE on the handshake.
